// File: rtl/delaymon_pkg.sv
// Shared types and constants for the stepdown delay-cell monitor.
package delaymon_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_e;

   // Which edges of the cell input start a measurement.
   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_BOTH = 2;

endpackage

// File: rtl/delaymon_stepdown_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect flop; reports level and edge pulses.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic lvl,
   output logic rise_c,
   output logic fall_c
);

   logic s1;
   logic s2;
   logic dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         dly <= 1'b0;
      end else begin
         s1  <= d;
         s2  <= s1;
         dly <= s2;
      end
   end

   assign lvl    = s2;
   assign rise_c = s2 & ~dly;
   assign fall_c = ~s2 & dly;

endmodule

// File: rtl/delaymon_stepdown.sv
// Measures the i-to-o edge delay of the stepdown fixed delay cell in CELCLK cycles
// and flags early, late, missing, overrun and spurious behaviour.
module delaymon_stepdown
   import delaymon_pkg::*;
#(
   parameter int unsigned CW      = 8,
   parameter int unsigned MIN_CYC = 1,
   parameter int unsigned MAX_CYC = 20,
   parameter int unsigned TIMEOUT = 63,
   parameter int unsigned EDGE    = 2
) (
   input  logic          CELCLK,
   input  logic          CELRSTN,
   input  logic          CELV,
   input  logic          CELG,
   input  logic          CELSUB,
   input  logic          i,
   input  logic          o,
   input  logic          clr,
   output logic [CW-1:0] meas,
   output logic          meas_vld,
   output logic          early,
   output logic          late,
   output logic          missing,
   output logic          err_sticky,
   output logic          busy
);

   localparam logic [CW-1:0] MIN_V   = CW'(MIN_CYC);
   localparam logic [CW-1:0] MAX_V   = CW'(MAX_CYC);
   localparam logic [CW-1:0] TO_V    = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] ONE_V   = CW'(1);

   // Supply/ground/substrate pins carry no logic.
   logic unused_pins_c;
   assign unused_pins_c = &{CELV, CELG, CELSUB};

   logic i_lvl, i_rise_c, i_fall_c;
   logic o_lvl, o_rise_c, o_fall_c;

   sync_edge u_sync_i (
      .clk    (CELCLK),
      .rst_n  (CELRSTN),
      .d      (i),
      .lvl    (i_lvl),
      .rise_c (i_rise_c),
      .fall_c (i_fall_c)
   );

   sync_edge u_sync_o (
      .clk    (CELCLK),
      .rst_n  (CELRSTN),
      .d      (o),
      .lvl    (o_lvl),
      .rise_c (o_rise_c),
      .fall_c (o_fall_c)
   );

   logic i_go_c;
   logic o_edge_c;

   assign i_go_c = (((EDGE == EDGE_RISE) || (EDGE == EDGE_BOTH)) && i_rise_c) ||
                   (((EDGE == EDGE_FALL) || (EDGE == EDGE_BOTH)) && i_fall_c);
   assign o_edge_c = o_rise_c | o_fall_c;

   state_e        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pol, pol_nxt;

   logic          res_vld_c;
   logic [CW-1:0] res_val_c;
   logic          res_miss_c;
   logic          spur_c;
   logic          ovr_c;
   logic          early_c;
   logic          late_c;
   logic          err_c;

   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         state <= IDLE;
         cnt   <= '0;
         pol   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pol   <= pol_nxt;
      end
   end

   // An o edge of the expected polarity always completes before a coincident i edge restarts.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      pol_nxt    = pol;
      res_vld_c  = 1'b0;
      res_val_c  = cnt;
      res_miss_c = 1'b0;
      spur_c     = 1'b0;
      ovr_c      = 1'b0;
      case (state)
         IDLE: begin
            if (i_go_c && o_edge_c && (o_lvl == i_lvl)) begin
               res_vld_c = 1'b1;
               res_val_c = '0;
            end else if (i_go_c) begin
               state_nxt = MEAS;
               cnt_nxt   = ONE_V;
               pol_nxt   = i_lvl;
               spur_c    = o_edge_c;
            end else if (o_edge_c) begin
               spur_c = 1'b1;
            end
         end
         MEAS: begin
            if (o_edge_c && (o_lvl == pol)) begin
               res_vld_c = 1'b1;
               res_val_c = cnt;
               state_nxt = IDLE;
               if (i_go_c) begin
                  state_nxt = MEAS;
                  cnt_nxt   = ONE_V;
                  pol_nxt   = i_lvl;
               end
            end else begin
               spur_c = o_edge_c;
               if (i_go_c) begin
                  ovr_c   = 1'b1;
                  cnt_nxt = ONE_V;
                  pol_nxt = i_lvl;
               end else if (cnt == TO_V) begin
                  res_vld_c  = 1'b1;
                  res_val_c  = TO_V;
                  res_miss_c = 1'b1;
                  state_nxt  = IDLE;
               end else if (cnt != CNT_MAX) begin
                  cnt_nxt = cnt + ONE_V;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign early_c = res_vld_c && (res_val_c < MIN_V);
   assign late_c  = res_vld_c && (res_miss_c || (res_val_c > MAX_V));
   assign err_c   = early_c | late_c | spur_c | ovr_c;

   // Result pulses and sticky error; a new error outranks a coincident clear.
   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         meas       <= '0;
         meas_vld   <= 1'b0;
         early      <= 1'b0;
         late       <= 1'b0;
         missing    <= 1'b0;
         err_sticky <= 1'b0;
         busy       <= 1'b0;
      end else begin
         meas_vld <= res_vld_c;
         early    <= early_c;
         late     <= late_c;
         missing  <= res_vld_c && res_miss_c;
         busy     <= (state_nxt == MEAS);
         if (res_vld_c) begin
            meas <= res_val_c;
         end
         if (err_c) begin
            err_sticky <= 1'b1;
         end else if (clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

endmodule
